// File: rtl/ezm_pkg.sv
// Shared types and constants for the ezm accumulator core and its program sequencer.
// Opcode patterns are expressed as mask/value pairs so decoders can match don't-care bits.
package ezm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int EZM_DEPTH     = 16;
    localparam int EZM_IW        = 6;
    localparam int EZM_DW        = 8;
    localparam int EZM_MAX_STEPS = 255;

    // OP_LOAD = 6'b1xxxxx, OP_BR = 6'b011xxx
    localparam logic [5:0] OP_LOAD_MASK = 6'b100000;
    localparam logic [5:0] OP_LOAD_VAL  = 6'b100000;
    localparam logic [5:0] OP_BR_MASK   = 6'b111000;
    localparam logic [5:0] OP_BR_VAL    = 6'b011000;

    function automatic logic is_op_load(input logic [5:0] instr);
        return (instr & OP_LOAD_MASK) == OP_LOAD_VAL;
    endfunction

    function automatic logic is_op_br(input logic [5:0] instr);
        return (instr & OP_BR_MASK) == OP_BR_VAL;
    endfunction

endpackage

// File: rtl/ezm_seq_ctrl_mem.sv
// Program store for the sequencer: synchronous write, asynchronous read, no array reset
// so a loaded program survives a sequencer reset.
module ezm_prog_mem
    import ezm_pkg::*;
#(
    parameter int DEPTH = EZM_DEPTH,
    parameter int IW    = EZM_IW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [IW-1:0] rd_data
);

    logic [IW-1:0] mem_r [DEPTH];

    // Word write from the load port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/ezm_seq_ctrl.sv
// Program sequencer for the ezm accumulator core: loads a program, feeds instructions in
// step with the core's fetch/execute phases, and captures the final accumulator.
module ezm_seq_ctrl
    import ezm_pkg::*;
#(
    parameter int DEPTH     = EZM_DEPTH,
    parameter int IW        = EZM_IW,
    parameter int DW        = EZM_DW,
    parameter int MAX_STEPS = EZM_MAX_STEPS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_clr,
    input  logic                   load_en,
    input  logic [IW-1:0]          load_data,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DW-1:0]          cpu_out,
    output logic [IW-1:0]          cpu_in,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] prog_len,
    output logic [DW-1:0]          result
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(MAX_STEPS + 1);

    state_t        state_r, state_s;
    logic          phase_r, phase_s;
    logic [SW-1:0] step_r, step_s;
    logic [IW-1:0] ir_r, ir_s;
    logic          timeout_r, timeout_s;
    logic [DW-1:0] result_r, result_s;
    logic          busy_r, done_r, cpu_rst_r;
    logic [PW-1:0] prog_len_r;
    logic          overflow_r;

    logic [IW-1:0] cpu_in_s;
    logic [IW-1:0] mem_rd_s;
    logic          load_ok_s;
    logic          mem_full_s;
    logic          mem_we_s;
    logic          start_ok_s;
    logic          abort_hit_s;
    logic          at_end_s;
    logic          budget_out_s;
    logic          run_next_s;

    assign load_ok_s    = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign mem_full_s   = (prog_len_r == PW'(DEPTH));
    assign mem_we_s     = load_ok_s && load_en && !load_clr && !mem_full_s;
    assign start_ok_s   = load_ok_s && start && (prog_len_r != {PW{1'b0}}) && !load_en && !load_clr;
    assign abort_hit_s  = abort && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    // In phase 0 the core presents its pc; anything at or past the program length ends the run.
    assign at_end_s     = (32'(cpu_out) >= 32'(prog_len_r));
    assign budget_out_s = (step_r == SW'(MAX_STEPS));
    assign run_next_s   = (state_s == ST_RUN) || (state_s == ST_DRAIN);

    ezm_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we_s),
        .wr_addr (prog_len_r[AW-1:0]),
        .wr_data (load_data),
        .rd_addr (cpu_out[AW-1:0]),
        .rd_data (mem_rd_s)
    );

    // Next-state, instruction feed and run bookkeeping.
    always_comb begin
        state_s   = state_r;
        phase_s   = 1'b0;
        step_s    = step_r;
        ir_s      = ir_r;
        timeout_s = timeout_r;
        result_s  = result_r;
        cpu_in_s  = {IW{1'b0}};
        if (abort_hit_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        state_s   = ST_RUN;
                        step_s    = {SW{1'b0}};
                        timeout_s = 1'b0;
                        ir_s      = {IW{1'b0}};
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RUN: begin
                    phase_s = ~phase_r;
                    if (phase_r) begin
                        cpu_in_s = ir_r;
                    end else if (at_end_s) begin
                        state_s = ST_DRAIN;
                        ir_s    = {IW{1'b0}};
                    end else if (budget_out_s) begin
                        timeout_s = 1'b1;
                        state_s   = ST_DRAIN;
                        ir_s      = {IW{1'b0}};
                    end else begin
                        cpu_in_s = mem_rd_s;
                        ir_s     = mem_rd_s;
                        step_s   = step_r + SW'(1);
                    end
                end
                // The core sits in its execute phase here, so cpu_out is the accumulator.
                ST_DRAIN: begin
                    result_s = cpu_out;
                    state_s  = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            phase_r   <= 1'b0;
            step_r    <= {SW{1'b0}};
            ir_r      <= {IW{1'b0}};
            timeout_r <= 1'b0;
            result_r  <= {DW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cpu_rst_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            phase_r   <= phase_s;
            step_r    <= step_s;
            ir_r      <= ir_s;
            timeout_r <= timeout_s;
            result_r  <= result_s;
            busy_r    <= run_next_s;
            done_r    <= (state_s == ST_DONE);
            cpu_rst_r <= ~run_next_s;
        end
    end

    // Load port: write pointer doubles as program length; load_clr wins over load_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_len_r <= {PW{1'b0}};
            overflow_r <= 1'b0;
        end else if (load_ok_s && load_clr) begin
            prog_len_r <= {PW{1'b0}};
            overflow_r <= 1'b0;
        end else if (load_ok_s && load_en) begin
            if (mem_full_s) begin
                overflow_r <= 1'b1;
            end else begin
                prog_len_r <= prog_len_r + PW'(1);
            end
        end
    end

    assign cpu_in   = cpu_in_s;
    assign cpu_rst  = cpu_rst_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign timeout  = timeout_r;
    assign overflow = overflow_r;
    assign prog_len = prog_len_r;
    assign result   = result_r;

endmodule
